// File: rtl/defines_pkg.sv
// Shared types and constants for the SPU-lite local store.
package defines_pkg;

    localparam int LS_QW_BYTES = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } ls_fill_state_t;

endpackage

// File: rtl/ls_sram_1p.sv
// Single-port quadword array: one read or write per cycle, registered read, write-first.
module ls_sram_1p #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [127:0]  wdata,
    output logic [127:0]  rdata
);

    logic [127:0] mem [DEPTH];
    logic [127:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (req) begin
            rdata_d = we ? wdata : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (req && we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spu_local_store.sv
// Quadword local store: data port with priority over an instruction-line fill engine.
// Optional LS_BOUNDS_CHECK_EN rejects accesses above the store size and reports ls_err.
module spu_local_store
    import defines_pkg::*;
#(
    parameter int LS_BYTES = 65536,
    parameter int LINE_QW  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [0:31]                ls_addr,
    input  logic                       ls_rd_en,
    input  logic                       ls_wr_en,
    input  logic [0:127]               ls_data_wr,
    output logic [0:127]               ls_data_rd,
    input  logic                       cache_wr,
    input  logic [0:31]                PC_out,
    input  logic                       flush,
    output logic                       ic_fill_valid,
    output logic [0:$clog2(LINE_QW)-1] ic_fill_idx,
    output logic [0:127]               ic_fill_data,
    output logic                       ic_fill_done,
    output logic                       ic_fill_busy,
    output logic                       ls_err
);

    localparam int AW    = $clog2(LS_BYTES);
    localparam int IW    = AW - $clog2(LS_QW_BYTES);
    localparam int LB    = $clog2(LINE_QW);
    localparam int DEPTH = LS_BYTES / LS_QW_BYTES;
    localparam logic [LB-1:0] LAST_BEAT = LB'(LINE_QW - 1);

    ls_fill_state_t   state_q, state_d;
    logic [LB-1:0]    cnt_q, cnt_d;
    logic [IW-LB-1:0] base_q, base_d;
    logic [LB-1:0]    idx_q, idx_d;
    logic             fv_q, fv_d;
    logic             done_q, done_d;
    logic             rd_pend_q, rd_pend_d;
    logic [127:0]     rd_hold_q, rd_hold_d;
    logic [127:0]     fdata_q, fdata_d;

    logic             data_req, fill_issue, flush_kill;
    logic             data_oob, pc_oob;
    logic             sram_req, sram_we;
    logic [IW-1:0]    sram_addr;
    logic [127:0]     sram_rdata;
    logic [IW-1:0]    data_idx;
    logic [IW-LB-1:0] pc_line;
    logic             unused_bits;

    assign data_idx = ls_addr[32-AW:27];
    assign pc_line  = PC_out[32-AW:27-LB];

`ifdef LS_BOUNDS_CHECK_EN
    logic err_q, err_d;

    assign data_oob    = |ls_addr[0:31-AW];
    assign pc_oob      = |PC_out[0:31-AW];
    assign unused_bits = ^{ls_addr[28:31], PC_out[28-LB:31]};
    assign err_d       = data_req & data_oob;
    assign ls_err      = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    // Without the check, upper address bits are dropped and accesses wrap.
    assign data_oob    = 1'b0;
    assign pc_oob      = 1'b0;
    assign unused_bits = ^{ls_addr[0:31-AW], ls_addr[28:31], PC_out[0:31-AW], PC_out[28-LB:31]};
    assign ls_err      = 1'b0;
`endif

    always_comb begin
        data_req   = ls_rd_en | ls_wr_en;
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        fill_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (cache_wr && !flush && !pc_oob) begin
                    state_d = FILL;
                    base_d  = pc_line;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                // A flush cycle issues nothing, so no beat can surface afterwards.
                if (flush) begin
                    state_d = IDLE;
                end else if (!data_req) begin
                    fill_issue = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        fv_d   = fill_issue;
        done_d = fill_issue && (cnt_q == LAST_BEAT);
        idx_d  = fill_issue ? cnt_q : idx_q;

        sram_we   = ls_wr_en & ~data_oob;
        sram_req  = (data_req & ~data_oob) | fill_issue;
        sram_addr = data_req ? data_idx : {base_q, cnt_q};

        rd_pend_d = ls_rd_en & ~data_oob;
        rd_hold_d = rd_pend_q ? sram_rdata : rd_hold_q;
        if (ls_rd_en && data_oob) begin
            rd_hold_d = '0;
        end
        fdata_d = fv_q ? sram_rdata : fdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            idx_q     <= '0;
            fv_q      <= 1'b0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_hold_q <= '0;
            fdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            fv_q      <= fv_d;
            done_q    <= done_d;
            rd_pend_q <= rd_pend_d;
            rd_hold_q <= rd_hold_d;
            fdata_q   <= fdata_d;
        end
    end

    ls_sram_1p #(
        .DEPTH(DEPTH),
        .AW   (IW)
    ) u_sram (
        .clk  (clk),
        .req  (sram_req),
        .we   (sram_we),
        .addr (sram_addr),
        .wdata(ls_data_wr),
        .rdata(sram_rdata)
    );

    // The array output register is shared; each consumer sees it only on its own beat.
    assign flush_kill    = flush & (state_q == FILL);
    assign ic_fill_valid = fv_q & ~flush_kill;
    assign ic_fill_done  = done_q & ~flush_kill;
    assign ic_fill_busy  = (state_q == FILL) | fv_q;
    assign ic_fill_idx   = idx_q;
    assign ic_fill_data  = fv_q ? sram_rdata : fdata_q;
    assign ls_data_rd    = rd_pend_q ? sram_rdata : rd_hold_q;

endmodule
